// File: rtl/sent_param_report_pkg.sv
// Shared definitions for the SENT parameter report path: payload word layout,
// FSM encoding, frame/counter sizing and the word packing helper.
package sent_param_report_pkg;

  localparam int unsigned FRAME_WORDS = 4;
  localparam int unsigned DROP_CNT_W  = 16;
  localparam int unsigned WORD_CNT_W  = $clog2(FRAME_WORDS);

  // Word 0 field offsets
  localparam int unsigned W0_ID_LSB      = 16;
  localparam int unsigned W0_CH_LSB      = 8;
  // Word 1 field offsets
  localparam int unsigned W1_CTICK_LSB   = 24;
  localparam int unsigned W1_LTICK_LSB   = 16;
  localparam int unsigned W1_PMODE_LSB   = 8;
  localparam int unsigned W1_PLEN_HI_LSB = 0;
  // Word 2 field offsets
  localparam int unsigned W2_PLEN_LO_LSB = 24;
  localparam int unsigned W2_CRC_BIT     = 16;
  localparam int unsigned W2_STATUS_LSB  = 8;
  localparam int unsigned W2_DLEN_LSB    = 0;
  // Word 3 field offsets
  localparam int unsigned W3_DATA_LSB    = 8;
  localparam int unsigned W3_SEQ_LSB     = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0]  channel;
    logic [7:0]  ctick_len;
    logic [7:0]  ltick_len;
    logic [1:0]  pause_mode;
    logic [15:0] pause_len;
    logic        crc_mode;
    logic [3:0]  status_nibble;
    logic [2:0]  data_len;
    logic [23:0] data_nibble;
  } rpt_fields_t;

  // Builds one payload word; bits not owned by a field stay zero.
  function automatic logic [31:0] pack_word(input rpt_fields_t f,
                                            input logic [15:0] id,
                                            input logic [7:0]  seq,
                                            input logic [WORD_CNT_W-1:0] idx);
    logic [31:0] w;
    w = '0;
    case (idx)
      2'd0: begin
        w[W0_ID_LSB +: 16] = id;
        w[W0_CH_LSB +: 8]  = f.channel;
      end
      2'd1: begin
        w[W1_CTICK_LSB +: 8]   = f.ctick_len;
        w[W1_LTICK_LSB +: 8]   = f.ltick_len;
        w[W1_PMODE_LSB +: 2]   = f.pause_mode;
        w[W1_PLEN_HI_LSB +: 8] = f.pause_len[15:8];
      end
      2'd2: begin
        w[W2_PLEN_LO_LSB +: 8] = f.pause_len[7:0];
        w[W2_CRC_BIT]          = f.crc_mode;
        w[W2_STATUS_LSB +: 4]  = f.status_nibble;
        w[W2_DLEN_LSB +: 3]    = f.data_len;
      end
      default: begin
        w[W3_DATA_LSB +: 24] = f.data_nibble;
        w[W3_SEQ_LSB +: 8]   = seq;
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sent_param_slot.sv
// One-deep pending request buffer with overwrite detection and a saturating
// drop counter.
module sent_param_slot
  import sent_param_report_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  rpt_fields_t           wr_data,
  input  logic                  rd_en,
  output logic                  pend_vld,
  output rpt_fields_t           pend_data,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic drop;

  // A write into an occupied slot that is not being drained this cycle loses the old entry.
  assign drop = wr_en && pend_vld && !rd_en;

  // Slot contents and occupancy; a write wins over a simultaneous read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_data <= '0;
    end else begin
      if (wr_en) begin
        pend_data <= wr_data;
        pend_vld  <= 1'b1;
      end else if (rd_en) begin
        pend_vld  <= 1'b0;
      end
    end
  end

  // Saturating count of overwritten requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end

endmodule

// File: rtl/sent_param_report.sv
// Packs a SENT channel parameter set into a 4-word UDP payload and streams it
// on the user UDP transmit AXI-Stream port.
module sent_param_report
  import sent_param_report_pkg::*;
#(
  parameter int unsigned ID_SENT_PARAM = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rpt_vld,
  input  logic [7:0]  rpt_channel,
  input  logic [7:0]  rpt_ctick_len,
  input  logic [7:0]  rpt_ltick_len,
  input  logic [1:0]  rpt_pause_mode,
  input  logic [15:0] rpt_pause_len,
  input  logic        rpt_crc_mode,
  input  logic [3:0]  rpt_status_nibble,
  input  logic [2:0]  rpt_data_len,
  input  logic [23:0] rpt_data_nibble,
  output logic [31:0] tx_axis_udp_tdata,
  output logic        tx_axis_udp_tvalid,
  output logic        tx_axis_udp_tlast,
  input  logic        tx_axis_udp_tready,
  output logic        rpt_busy,
  output logic [15:0] rpt_drop_cnt
);

  localparam logic [15:0]           FRAME_ID  = 16'(ID_SENT_PARAM);
  localparam logic [WORD_CNT_W-1:0] LAST_WORD = WORD_CNT_W'(FRAME_WORDS - 1);

  rpt_fields_t             req;
  rpt_fields_t             pend;
  rpt_fields_t             frame;
  logic                    pend_vld;
  logic                    consume;
  state_t                  state;
  logic [WORD_CNT_W-1:0]   word_cnt;
  logic [7:0]              seq;

  // Gather the request inputs into one record for the slot.
  always_comb begin
    req               = '0;
    req.channel       = rpt_channel;
    req.ctick_len     = rpt_ctick_len;
    req.ltick_len     = rpt_ltick_len;
    req.pause_mode    = rpt_pause_mode;
    req.pause_len     = rpt_pause_len;
    req.crc_mode      = rpt_crc_mode;
    req.status_nibble = rpt_status_nibble;
    req.data_len      = rpt_data_len;
    req.data_nibble   = rpt_data_nibble;
  end

  assign consume = (state == ST_IDLE) && pend_vld;

  sent_param_slot u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (rpt_vld),
    .wr_data   (req),
    .rd_en     (consume),
    .pend_vld  (pend_vld),
    .pend_data (pend),
    .drop_cnt  (rpt_drop_cnt)
  );

  // Frame FSM: latch the pending entry, then stream it one word per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      seq      <= '0;
      frame    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pend_vld) begin
            frame    <= pend;
            word_cnt <= '0;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tx_axis_udp_tready) begin
            word_cnt <= word_cnt + WORD_CNT_W'(1);
            if (word_cnt == LAST_WORD) begin
              seq   <= seq + 8'd1;
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output word mux; outputs are decoded from registered state so they are
  // stable under backpressure and drop as soon as reset asserts.
  always_comb begin
    tx_axis_udp_tvalid = (state == ST_SEND);
    tx_axis_udp_tlast  = tx_axis_udp_tvalid && (word_cnt == LAST_WORD);
    rpt_busy           = tx_axis_udp_tvalid;
    tx_axis_udp_tdata  = '0;
    if (tx_axis_udp_tvalid) begin
      tx_axis_udp_tdata = pack_word(frame, FRAME_ID, seq, word_cnt);
    end
  end

endmodule

// File: tb/tb_sent_param_report.sv
// Scoreboard bench for sent_param_report: stimulus pushes expected payload
// words, a negedge monitor pops and compares on every handshake.
module tb_sent_param_report;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rpt_vld;
  logic [7:0]  rpt_channel;
  logic [7:0]  rpt_ctick_len;
  logic [7:0]  rpt_ltick_len;
  logic [1:0]  rpt_pause_mode;
  logic [15:0] rpt_pause_len;
  logic        rpt_crc_mode;
  logic [3:0]  rpt_status_nibble;
  logic [2:0]  rpt_data_len;
  logic [23:0] rpt_data_nibble;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic        rpt_busy;
  logic [15:0] rpt_drop_cnt;

  sent_param_report #(.ID_SENT_PARAM(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .rpt_vld            (rpt_vld),
    .rpt_channel        (rpt_channel),
    .rpt_ctick_len      (rpt_ctick_len),
    .rpt_ltick_len      (rpt_ltick_len),
    .rpt_pause_mode     (rpt_pause_mode),
    .rpt_pause_len      (rpt_pause_len),
    .rpt_crc_mode       (rpt_crc_mode),
    .rpt_status_nibble  (rpt_status_nibble),
    .rpt_data_len       (rpt_data_len),
    .rpt_data_nibble    (rpt_data_nibble),
    .tx_axis_udp_tdata  (tdata),
    .tx_axis_udp_tvalid (tvalid),
    .tx_axis_udp_tlast  (tlast),
    .tx_axis_udp_tready (tready),
    .rpt_busy           (rpt_busy),
    .rpt_drop_cnt       (rpt_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  ct;
    logic [7:0]  lt;
    logic [1:0]  pm;
    logic [15:0] pl;
    logic        crc;
    logic [3:0]  st;
    logic [2:0]  dl;
    logic [23:0] dn;
  } req_t;

  logic [32:0] exp_q[$];
  logic [7:0]  exp_seq = 8'd0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic [7:0] ch, input logic [7:0] ct, input logic [7:0] lt,
                              input logic [1:0] pm, input logic [15:0] pl, input logic crc,
                              input logic [3:0] st, input logic [2:0] dl, input logic [23:0] dn);
    req_t r;
    r.ch = ch; r.ct = ct; r.lt = lt; r.pm = pm; r.pl = pl;
    r.crc = crc; r.st = st; r.dl = dl; r.dn = dn;
    return r;
  endfunction

  // Reference payload words built by concatenation from the documented layout.
  function automatic logic [31:0] exp_word(input req_t r, input logic [7:0] s, input int idx);
    case (idx)
      0:       return {16'h0002, r.ch, 8'h00};
      1:       return {r.ct, r.lt, 6'b0, r.pm, r.pl[15:8]};
      2:       return {r.pl[7:0], 7'b0, r.crc, 4'b0, r.st, 5'b0, r.dl};
      default: return {r.dn, s};
    endcase
  endfunction

  task automatic push_frame(input req_t r);
    for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), exp_word(r, exp_seq, i)});
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic drive(input req_t r);
    rpt_channel = r.ch; rpt_ctick_len = r.ct; rpt_ltick_len = r.lt;
    rpt_pause_mode = r.pm; rpt_pause_len = r.pl; rpt_crc_mode = r.crc;
    rpt_status_nibble = r.st; rpt_data_len = r.dl; rpt_data_nibble = r.dn;
  endtask

  // Returns 1 ns after the edge following the sampling edge.
  task automatic send(input req_t r);
    @(posedge clk); #1;
    drive(r); rpt_vld = 1'b1;
    @(posedge clk); #1;
    rpt_vld = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tvalid) begin
        done = 1'b1;
        break;
      end
    end
    chk({name, "_drain"}, {63'd0, done}, 64'd1);
  endtask

  // Monitor: compares every accepted word and checks hold stability under backpressure.
  logic        held = 1'b0;
  logic [32:0] held_word;
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) chk("hold", {30'd0, tvalid, tlast, tdata}, {30'd0, 1'b1, held_word});
      if (tvalid && tready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {31'd0, tlast, tdata}, 64'd0 - 64'd1);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          chk("word", {31'd0, tlast, tdata}, {31'd0, e});
        end
      end
      held      = tvalid && !tready;
      held_word = {tlast, tdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req_t r, a, b, c, d;
    int   hs0;
    rst_n = 1'b0; rpt_vld = 1'b0; tready = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset state
    cycles(3);
    @(negedge clk);
    chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("rst_tlast", {63'd0, tlast}, 64'd0);
    chk("rst_tdata", {32'd0, tdata}, 64'd0);
    chk("rst_busy", {63'd0, rpt_busy}, 64'd0);
    chk("rst_drop", {48'd0, rpt_drop_cnt}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cycles(2);

    // Single request, hand-computed words and latency
    exp_q.push_back({1'b0, 32'h00020300});
    exp_q.push_back({1'b0, 32'h03050101});
    exp_q.push_back({1'b0, 32'h00010A06});
    exp_q.push_back({1'b1, 32'h12345600});
    exp_seq = 8'd1;
    send(mk(8'd3, 8'd3, 8'd5, 2'd1, 16'h0100, 1'b1, 4'hA, 3'd6, 24'h123456));
    @(negedge clk);
    chk("lat_slot_cycle_tvalid", {63'd0, tvalid}, 64'd0);
    @(negedge clk);
    chk("lat_w0_tvalid", {63'd0, tvalid}, 64'd1);
    chk("lat_w0_busy", {63'd0, rpt_busy}, 64'd1);
    chk("lat_w0_data", {32'd0, tdata}, 64'h00020300);
    drain("single");

    // Backpressure: tready pattern 1,0,0,1 repeating
    r = mk(8'h11, 8'h22, 8'h33, 2'd2, 16'hBEEF, 1'b0, 4'h5, 3'd3, 24'hABCDEF);
    hs0 = hs_cnt;
    push_frame(r);
    send(r);
    for (int i = 0; i < 24; i++) begin
      tready = (i % 4 == 0) || (i % 4 == 3);
      @(posedge clk); #1;
    end
    tready = 1'b1;
    drain("backpressure");
    chk("bp_handshakes", 64'(hs_cnt - hs0), 64'd4);

    // Overflow: A in flight and stalled, B/C/D arrive, only A and D go out
    tready = 1'b0;
    a = mk(8'hA0, 8'd1, 8'd2, 2'd0, 16'h1234, 1'b0, 4'h1, 3'd1, 24'h00000A);
    b = mk(8'hB0, 8'd3, 8'd4, 2'd1, 16'h5678, 1'b1, 4'h2, 3'd2, 24'h00000B);
    c = mk(8'hC0, 8'd5, 8'd6, 2'd2, 16'h9ABC, 1'b0, 4'h3, 3'd3, 24'h00000C);
    d = mk(8'hD0, 8'd7, 8'd8, 2'd3, 16'hDEF0, 1'b1, 4'h4, 3'd4, 24'h00000D);
    push_frame(a);
    send(a);
    cycles(2);
    send(b);
    send(c);
    send(d);
    @(negedge clk);
    chk("ovf_drop_cnt", {48'd0, rpt_drop_cnt}, 64'd2);
    push_frame(d);
    @(posedge clk); #1 tready = 1'b1;
    drain("overflow");

    // Coincident load: second request sampled on the edge that consumes the first
    a = mk(8'h55, 8'h10, 8'h20, 2'd1, 16'h0F0F, 1'b1, 4'hC, 3'd5, 24'h654321);
    b = mk(8'h66, 8'h30, 8'h40, 2'd2, 16'hF0F0, 1'b0, 4'h3, 3'd2, 24'h0FEDCB);
    push_frame(a);
    push_frame(b);
    @(posedge clk); #1;
    drive(a); rpt_vld = 1'b1;
    @(posedge clk); #1;
    drive(b);
    @(posedge clk); #1;
    rpt_vld = 1'b0;
    drain("coincident");
    chk("coin_drop_cnt", {48'd0, rpt_drop_cnt}, 64'd2);

    // Reset while word 2 is held; a pending request must be discarded
    tready = 1'b0;
    r = mk(8'h77, 8'h01, 8'h02, 2'd0, 16'h0001, 1'b0, 4'h0, 3'd0, 24'h777777);
    push_frame(r);
    send(r);
    @(posedge clk); #1 tready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 tready = 1'b0;
    @(negedge clk);
    chk("pre_rst_tdata", {32'd0, tdata}, {32'd0, exp_word(r, exp_seq - 8'd1, 2)});
    send(mk(8'h88, 8'd9, 8'd9, 2'd1, 16'h0909, 1'b1, 4'h9, 3'd7, 24'h888888));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", {63'd0, tvalid}, 64'd0);
    chk("mid_rst_tlast", {63'd0, tlast}, 64'd0);
    chk("mid_rst_tdata", {32'd0, tdata}, 64'd0);
    chk("mid_rst_busy", {63'd0, rpt_busy}, 64'd0);
    chk("mid_rst_drop", {48'd0, rpt_drop_cnt}, 64'd0);
    exp_q.delete();
    exp_seq = 8'd0;
    tready = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(6);
    @(negedge clk);
    chk("post_rst_no_pending", {63'd0, tvalid}, 64'd0);
    r = mk(8'h99, 8'hAA, 8'hBB, 2'd3, 16'hCCDD, 1'b1, 4'hE, 3'd6, 24'hEEFF00);
    push_frame(r);
    send(r);
    drain("post_reset_seq0");

    // Seq wrap: 256 more frames, the last one carries seq 0x00
    for (int k = 0; k < 256; k++) begin
      logic [7:0] kb;
      kb = 8'(k);
      r = mk(kb, ~kb, kb ^ 8'h5A, kb[1:0], {kb, ~kb}, kb[0], kb[3:0], kb[2:0], {kb, 8'h3C, kb});
      if (k == 255) chk("wrap_model_seq", {56'd0, exp_seq}, 64'd0);
      push_frame(r);
      send(r);
      drain("wrap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sent_param_report.md
# sent_param_report

Packs one SENT channel parameter set into a 4-word UDP payload and streams it out on the user UDP transmit AXI-Stream interface. It is the transmit-side counterpart of the SENT parameter-frame parser: its payload uses the same word layout, so the host can read back or echo the configuration applied to a channel. A one-deep pending buffer absorbs requests that arrive while a frame is in flight, and overflows are counted.

## Interface
- ID_SENT_PARAM, default 2: frame ID placed in word 0 [31:16].
- clk  in  1  module clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- rpt_vld  in  1  single-cycle request; samples all rpt_* fields.
- rpt_channel  in  8  channel index.
- rpt_ctick_len  in  8  tick length, in us.
- rpt_ltick_len  in  8  low-pulse tick count.
- rpt_pause_mode  in  2  pause mode.
- rpt_pause_len  in  16  pause length, in ticks.
- rpt_crc_mode  in  1  CRC mode.
- rpt_status_nibble  in  4  status/communication nibble.
- rpt_data_len  in  3  data nibble count.
- rpt_data_nibble  in  24  {nibble1..nibble6}.
- tx_axis_udp_tdata  out  32  payload word.
- tx_axis_udp_tvalid  out  1  word valid.
- tx_axis_udp_tlast  out  1  high on word 3.
- tx_axis_udp_tready  in  1  downstream ready.
- rpt_busy  out  1  high while in SEND.
- rpt_drop_cnt  out  16  saturating count of overwritten pending requests.

## Operation
- Payload words:
  - w0: [31:16] ID_SENT_PARAM[15:0], [15:8] channel, [7:0] 0.
  - w1: [31:24] ctick_len, [23:16] ltick_len, [15:10] 0, [9:8] pause_mode, [7:0] pause_len[15:8].
  - w2: [31:24] pause_len[7:0], [23:17] 0, [16] crc_mode, [15:12] 0, [11:8] status_nibble, [7:3] 0, [2:0] data_len.
  - w3: [31:8] data_nibble, [7:0] seq.
- Pending slot: on rpt_vld, all fields are written to the pending slot and pend_vld is set.
  - If pend_vld is already 1 and the slot is not consumed in the same cycle, the old entry is overwritten and rpt_drop_cnt increments (saturates at 0xFFFF).
  - If rpt_vld coincides with consumption, the new entry replaces the slot, pend_vld stays 1, and no drop is counted.
- FSM states:
  - IDLE: when pend_vld = 1, load the frame register from the slot, clear pend_vld, and go to SEND with word_cnt = 0.
  - SEND: tvalid = 1 and tdata = word[word_cnt]. On each tvalid && tready, word_cnt increments. On the word-3 handshake: seq increments (8-bit, wraps 255 to 0) and the FSM returns to IDLE.
- No field checking. Values are passed through verbatim; only the unused bits are forced to 0.

## Timing
- Reset values (async on rst_n low): tvalid 0, tlast 0, tdata 0, rpt_busy 0, rpt_drop_cnt 0, seq 0, pend_vld 0, state IDLE, word_cnt 0.
- Latency: rpt_vld sampled at edge N loads the slot. IDLE consumes it at edge N+1, and tvalid is high with w0 after edge N+1.
- With tready held high, a frame takes 4 consecutive beats. Back-to-back frames have exactly one idle cycle between them (the IDLE load cycle).
- AXIS rules: tdata and tlast are held stable while tvalid && !tready. tvalid never drops mid-frame except on reset.
- tlast = (word_cnt == 3) && tvalid.
- The frame register is isolated from the slot: rpt_vld during SEND never alters the frame in flight.
- Reset mid-frame: tvalid drops immediately and the frame is truncated. The pending request is discarded. The first frame after reset carries seq 0.

## Structure
- Shared package holds:
  - the word-layout bit positions (field offsets per word),
  - the state encoding (IDLE, SEND),
  - the FRAME_WORDS = 4 constant,
  - the DROP_CNT_W = 16 constant.
- A single sub-module, sent_param_slot, is natural. It holds the pending buffer, the overwrite detection and the drop counter. The top level holds the FSM, word mux and seq counter.

## Test plan
- Single request: rpt_vld with channel 3, ctick 3, ltick 5, pause_mode 1, pause_len 0x0100, crc 1, status 0xA, data_len 6, data 0x123456, tready 1 -> words 0x00020300, 0x03050101, 0x00010A06, 0x12345600; tlast on beat 4; w0 appears 1 cycle after the sampling edge.
- Backpressure: tready toggles 1,0,0,1,... -> each word holds stable until accepted; exactly 4 handshakes; seq in the next frame is 0x01.
- Overflow: 3 requests during one stalled frame (A in flight; B, C, D arrive) -> frames A and D are sent; rpt_drop_cnt = 2.
- Coincident load: rpt_vld in the same cycle IDLE consumes the slot -> the new entry is sent as the next frame; rpt_drop_cnt is unchanged.
- Reset mid-frame: rst_n pulsed low during word 2 -> tvalid 0 immediately; all outputs at reset values; the next request is sent with seq 0.
- Seq wrap: 257 frames -> frame 257 has w3[7:0] = 0x00.
